kmer_stream_hash_ctrl: RTL and testbench
========================================

// Module: kmer_stream_hash_ctrl
// PURPOSE
//  Sequencer around the base-4 k-mer hash datapath: accepts a DNA character
//  stream (valid/ready), keeps a rolling 2-bit/base window hash and emits one
//  hash per full K-base window with its start position.
//  Handles sequence start/end, non-ACGT bases and output backpressure.
//  Sits between the read buffer and downstream k-mer lookup/match logic.
// PARAMETERS
//  K       4   bases per k-mer window (1..16)
//  HASH_W  32  hash_out width (>= 2*K)
//  POS_W   16  position/skip counter width
// PORTS
//  clk         in   1       system clock
//  rst         in   1       async reset, active-high
//  start       in   1       pulse: begin new sequence (honoured in IDLE only)
//  char_valid  in   1       char_in valid
//  char_in     in   8       ASCII base
//  char_last   in   1       final char of sequence (qualified by accept)
//  char_ready  out  1       controller can accept char this cycle
//  hash_valid  out  1       hash_out/hash_pos valid
//  hash_ready  in   1       downstream accepts hash
//  hash_out    out  HASH_W  window hash, bits [2K-1:0] used, rest 0
//  hash_pos    out  POS_W   index of first base of window
//  skip_cnt    out  POS_W   non-ACGT chars this sequence
//  busy        out  1       state != IDLE
//  done        out  1       1-cycle pulse: sequence finished
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, window/counters cleared; reset
//    mid-sequence drops any pending hash, no done pulse.
//  - Encoding: 'A'(65)=0 'T'(84)=1 'C'(67)=2 'G'(71)=3; all else invalid.
//  - accept = char_valid & char_ready;
//    char_ready = (state==RUN) & (!hash_valid | hash_ready).
//  - States: IDLE -start-> RUN (clear hash, fill, idx, skip_cnt);
//    RUN -accept & char_last-> DRAIN; DRAIN -(!hash_valid)-> IDLE, done=1.
//    start outside IDLE ignored.
//  - Valid base on accept: win <= ((win<<2)|code) & (2^(2K)-1);
//    fill <= min(fill+1, K); idx <= idx+1 (wraps mod 2^POS_W).
//  - If fill+1 >= K: hash_valid=1 next cycle, hash_out=new win,
//    hash_pos=idx-(K-1) (mod 2^POS_W). Latency 1 clk accept->hash_valid.
//  - Invalid base on accept: win=0, fill=0, idx++, skip_cnt++ (saturates);
//    no hash produced.
//  - hash_valid, hash_out, hash_pos held stable until hash_ready; a new hash
//    may load the same cycle the old one is taken (full throughput).
//  - Sequence shorter than K or all invalid: no hashes; done still pulses.
//  - char_last on invalid base still ends sequence.
//  - done: high exactly 1 cycle on DRAIN->IDLE; skip_cnt holds until next start.
// CONFIGURATION
//  KMER_MATCH_EN defined: adds ports target_hash in HASH_W and
//   match out 1; match=1 iff hash_valid & (hash_out==target_hash),
//   registered with hash (same cycle as hash_valid), reset 0.
//  Undefined: ports absent, no compare logic.
// TESTING (K=4)
//  1. start; "ATCG", last on G -> one hash 0x1B pos 0; done 1 clk after take.
//  2. "ATCGA" -> 0x1B pos 0, then 0x6C pos 1; exactly 2 hashes.
//  3. "ATNCGAT" -> single hash 0xB1 pos 3, skip_cnt=1.
//  4. hash_ready low 5 clks mid-stream -> char_ready low, hash_out stable,
//     no hash lost.
//  5. rst mid-stream -> all outputs 0 next edge; no done; new start works.
//  6. KMER_MATCH_EN, target_hash=0x6C, "ATCGA" -> match=1 only on 2nd hash.

Source files
------------

// File: rtl/kmer_stream_hash_ctrl.sv
// kmer_stream_hash_ctrl
//
// Sequencer around a base-4 k-mer rolling hash. Accepts an ASCII DNA
// character stream (valid/ready), keeps a 2-bit-per-base window of the last
// K valid bases and emits one hash per complete K-base window together with
// the index of the window's first base. Non-ACGT characters restart the
// window and are counted. Output hashes are held until downstream takes them.
//
// Optional feature macro: KMER_MATCH_EN
//   When defined, adds target_hash input and match output; match is
//   registered alongside each hash and is high iff hash_out == target_hash.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   start        begin a new sequence (only honoured while idle)
//   char_valid   char_in is valid
//   char_in      ASCII base
//   char_last    final character of the sequence (qualified by accept)
//   char_ready   controller can accept a character this cycle
//   hash_valid   hash_out / hash_pos valid
//   hash_ready   downstream accepts the hash
//   hash_out     window hash, bits [2K-1:0] used, upper bits zero
//   hash_pos     index of the first base of the window
//   skip_cnt     non-ACGT characters seen in this sequence (saturating)
//   busy         controller is not idle
//   done         single-cycle pulse when the sequence has fully drained
//   target_hash  (KMER_MATCH_EN) hash to compare against
//   match        (KMER_MATCH_EN) current hash equals target_hash

module kmer_stream_hash_ctrl #(
  parameter int K      = 4,
  parameter int HASH_W = 32,
  parameter int POS_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              char_valid,
  input  logic [7:0]        char_in,
  input  logic              char_last,
  output logic              char_ready,
  output logic              hash_valid,
  input  logic              hash_ready,
  output logic [HASH_W-1:0] hash_out,
  output logic [POS_W-1:0]  hash_pos,
  output logic [POS_W-1:0]  skip_cnt,
  output logic              busy,
  output logic              done
`ifdef KMER_MATCH_EN
  ,
  input  logic [HASH_W-1:0] target_hash,
  output logic              match
`endif
);

  localparam int WIN_W  = 2 * K;
  localparam int FILL_W = 5;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_next;
  logic [WIN_W-1:0]   win;
  logic [FILL_W-1:0]  fill;
  logic [POS_W-1:0]   idx;

  logic               code_valid;
  logic [1:0]         code;
  logic               accept;
  logic               seq_start;
  logic [WIN_W-1:0]   win_next;
  logic [FILL_W-1:0]  fill_inc;
  logic               hash_load;

  // Map ASCII bases onto their 2-bit codes; anything else breaks the window.
  always_comb begin
    code_valid = 1'b1;
    code       = 2'd0;
    case (char_in)
      8'd65:   code = 2'd0;
      8'd84:   code = 2'd1;
      8'd67:   code = 2'd2;
      8'd71:   code = 2'd3;
      default: code_valid = 1'b0;
    endcase
  end

  // Shifting inside a WIN_W-wide expression drops the oldest base for free.
  assign accept    = char_valid & char_ready;
  assign seq_start = (state == IDLE) & start;
  assign win_next  = (win << 2) | WIN_W'(code);
  assign fill_inc  = fill + 1'b1;
  assign hash_load = accept & code_valid & (fill_inc >= FILL_W'(K));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: DRAIN waits for the final hash to be taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && char_last) state_next = DRAIN;
      DRAIN:   if (!hash_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: a new char is only taken if the output slot is free or
  // being emptied this cycle, which keeps full throughput under ready=1.
  always_comb begin
    char_ready = (state == RUN) & (~hash_valid | hash_ready);
    busy       = (state != IDLE);
    done       = (state == DRAIN) & ~hash_valid;
  end

  // Window, counters and the output hash slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win        <= '0;
      fill       <= '0;
      idx        <= '0;
      skip_cnt   <= '0;
      hash_valid <= 1'b0;
      hash_out   <= '0;
      hash_pos   <= '0;
    end else if (seq_start) begin
      win        <= '0;
      fill       <= '0;
      idx        <= '0;
      skip_cnt   <= '0;
      hash_valid <= 1'b0;
      hash_out   <= '0;
      hash_pos   <= '0;
    end else begin
      if (accept) begin
        idx <= idx + 1'b1;
        if (code_valid) begin
          win  <= win_next;
          fill <= (fill_inc >= FILL_W'(K)) ? FILL_W'(K) : fill_inc;
        end else begin
          win  <= '0;
          fill <= '0;
          if (skip_cnt != {POS_W{1'b1}}) skip_cnt <= skip_cnt + 1'b1;
        end
      end
      if (hash_load) begin
        hash_valid <= 1'b1;
        hash_out   <= HASH_W'(win_next);
        hash_pos   <= idx - POS_W'(K - 1);
      end else if (hash_ready) begin
        hash_valid <= 1'b0;
      end
    end
  end

`ifdef KMER_MATCH_EN
  // Compare result travels with the hash it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match <= 1'b0;
    end else if (seq_start) begin
      match <= 1'b0;
    end else if (hash_load) begin
      match <= (HASH_W'(win_next) == target_hash);
    end else if (hash_ready) begin
      match <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_kmer_stream_hash_ctrl.sv
// tb_kmer_stream_hash_ctrl
//
// Randomized bench for kmer_stream_hash_ctrl with K=4. A reference model
// tracks the run of valid bases since the last non-ACGT character and
// predicts every window hash and its start position into a queue; each
// presented hash is compared against the queue head.

module tb_kmer_stream_hash_ctrl;

  localparam int K      = 4;
  localparam int HASH_W = 32;
  localparam int POS_W  = 16;

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic [HASH_W-1:0] h;
    logic [POS_W-1:0]  p;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              char_valid = 1'b0;
  logic [7:0]        char_in = 8'd0;
  logic              char_last = 1'b0;
  logic              char_ready;
  logic              hash_valid;
  logic              hash_ready = 1'b0;
  logic [HASH_W-1:0] hash_out;
  logic [POS_W-1:0]  hash_pos;
  logic [POS_W-1:0]  skip_cnt;
  logic              busy;
  logic              done;
`ifdef KMER_MATCH_EN
  logic [HASH_W-1:0] target_hash = '0;
  logic              match;
`endif

  kmer_stream_hash_ctrl #(.K(K), .HASH_W(HASH_W), .POS_W(POS_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .char_valid (char_valid),
    .char_in    (char_in),
    .char_last  (char_last),
    .char_ready (char_ready),
    .hash_valid (hash_valid),
    .hash_ready (hash_ready),
    .hash_out   (hash_out),
    .hash_pos   (hash_pos),
    .skip_cnt   (skip_cnt),
    .busy       (busy),
    .done       (done)
`ifdef KMER_MATCH_EN
    ,
    .target_hash(target_hash),
    .match      (match)
`endif
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state.
  exp_t        exp_q[$];
  int          run_codes[$];
  logic [15:0] m_idx  = '0;
  int          m_skip = 0;
  int          done_seen = 0;
  bit          hold_low = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int base_code(input byte unsigned c);
    case (c)
      "A": return 0;
      "T": return 1;
      "C": return 2;
      "G": return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bq_t to_bytes(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Downstream ready: random, unless a test pins it low.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      hash_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor and reference model, evaluated mid-cycle when inputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      run_codes.delete();
      m_idx  = '0;
      m_skip = 0;
    end else begin
      if (done) done_seen++;
      if (hash_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_hash", 64'(hash_valid), 64'd0);
        end else begin
          checkOutput("hash_out", 64'(hash_out), 64'(exp_q[0].h));
          checkOutput("hash_pos", 64'(hash_pos), 64'(exp_q[0].p));
`ifdef KMER_MATCH_EN
          checkOutput("match", 64'(match), 64'(exp_q[0].h == target_hash));
`endif
          if (hash_ready) void'(exp_q.pop_front());
        end
      end
      if (start && !busy) begin
        exp_q.delete();
        run_codes.delete();
        m_idx  = '0;
        m_skip = 0;
      end
      if (char_valid && char_ready) begin
        int c;
        c = base_code(char_in);
        if (c < 0) begin
          run_codes.delete();
          if (m_skip < 65535) m_skip++;
        end else begin
          run_codes.push_back(c);
          if (run_codes.size() > K) void'(run_codes.pop_front());
          if (run_codes.size() == K) begin
            exp_t e;
            e.h = '0;
            foreach (run_codes[j]) e.h = e.h * 4 + HASH_W'(run_codes[j]);
            e.p = m_idx - 16'(K - 1);
            exp_q.push_back(e);
          end
        end
        m_idx = m_idx + 16'd1;
      end
    end
  end

  // Runs one sequence; optionally stalls downstream for 5 cycles right
  // after the character at stall_at-1 and checks the input side backs up.
  task automatic applyStimulus(input bq_t seq, input bit with_last, input int stall_at);
    int  waited;
    bit  got;
    done_seen = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < seq.size(); i++) begin
      if (stall_at >= 0 && i == stall_at - 1) hold_low = 1'b1;
      if ($urandom_range(0, 3) == 0 && stall_at < 0) begin
        char_valid = 1'b0;
        @(posedge clk); #1;
      end
      char_valid = 1'b1;
      char_in    = seq[i];
      char_last  = with_last && (i == seq.size() - 1);
      if (stall_at >= 0 && i == stall_at) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checkOutput("stall_char_ready", 64'(char_ready), 64'd0);
          checkOutput("stall_hash_valid", 64'(hash_valid), 64'd1);
          @(posedge clk); #1;
        end
        hold_low = 1'b0;
      end
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 200) begin
        @(negedge clk);
        got = char_ready;
        @(posedge clk); #1;
        waited++;
      end
      if (!got) checkOutput("char_accept_timeout", 64'd0, 64'd1);
    end
    char_valid = 1'b0;
    char_last  = 1'b0;
    if (with_last) begin
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 300) begin
        @(negedge clk);
        got = done;
        waited++;
      end
      if (!got) begin
        checkOutput("done_timeout", 64'd0, 64'd1);
      end else begin
        checkOutput("pending_at_done", 64'(exp_q.size()), 64'd0);
        checkOutput("skip_cnt", 64'(skip_cnt), 64'(m_skip));
        @(negedge clk);
        checkOutput("done_width", 64'(done), 64'd0);
        checkOutput("busy_after_done", 64'(busy), 64'd0);
        checkOutput("skip_cnt_hold", 64'(skip_cnt), 64'(m_skip));
        checkOutput("done_count", 64'(done_seen), 64'd1);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_hash_valid"}, 64'(hash_valid), 64'd0);
    checkOutput({tag, "_hash_out"},   64'(hash_out),   64'd0);
    checkOutput({tag, "_hash_pos"},   64'(hash_pos),   64'd0);
    checkOutput({tag, "_skip_cnt"},   64'(skip_cnt),   64'd0);
    checkOutput({tag, "_busy"},       64'(busy),       64'd0);
    checkOutput({tag, "_done"},       64'(done),       64'd0);
    checkOutput({tag, "_char_ready"}, 64'(char_ready), 64'd0);
`ifdef KMER_MATCH_EN
    checkOutput({tag, "_match"},      64'(match),      64'd0);
`endif
  endtask

  initial begin
    string bases;
    bq_t   seq;
    bases = "ATCG";

    #2 checkAllZero("reset");
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

`ifdef KMER_MATCH_EN
    target_hash = 32'h6C;
`endif
    $display("[TB] directed sequences");
    applyStimulus(to_bytes("ATCG"), 1'b1, -1);
    applyStimulus(to_bytes("ATCGA"), 1'b1, -1);
    applyStimulus(to_bytes("ATNCGAT"), 1'b1, -1);
    applyStimulus(to_bytes("AT"), 1'b1, -1);
    applyStimulus(to_bytes("NXN"), 1'b1, -1);
    applyStimulus(to_bytes("ATCGTTAGCN"), 1'b1, -1);

    $display("[TB] downstream stall");
    applyStimulus(to_bytes("ATCGACGT"), 1'b1, 4);

    $display("[TB] reset mid-sequence");
    applyStimulus(to_bytes("ATCGAT"), 1'b0, -1);
    hold_low = 1'b1;
    @(posedge clk); #3 rst = 1'b1;
    #1 checkAllZero("midreset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    hold_low = 1'b0;
    repeat (3) @(posedge clk);
    #1 checkOutput("midreset_no_done", 64'(done_seen), 64'd0);
    applyStimulus(to_bytes("GGCCA"), 1'b1, -1);

    $display("[TB] random sequences");
    for (int n = 0; n < 40; n++) begin
      int len;
      seq.delete();
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        int r;
        r = $urandom_range(0, 11);
        if (r == 0)      seq.push_back(8'($urandom_range(0, 255)));
        else if (r == 1) seq.push_back("N");
        else             seq.push_back(bases[$urandom_range(0, 3)]);
      end
`ifdef KMER_MATCH_EN
      target_hash = 32'($urandom_range(0, 255));
`endif
      applyStimulus(seq, 1'b1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
